// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one registered pipeline stage with valid/ready handshake,
// flush, and a saturating count of stalled cycles.
//
// Build option: define PIPE_STAGE_REG_SKID_EN to add a one-entry skid
// buffer. ready_o then comes straight from a flop, which cuts the
// combinational ready_i -> ready_o path. Without the macro, ready_o is
// !valid_o || ready_i.
//
// A bubble (valid_o = 0) always carries an all-zero control bundle, so it
// can never write memory or the register file. The data bundle keeps its
// last loaded value.

module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned DATA_W = 69,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              valid_q,     valid_d;
    logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // The output register may take a new value when it is empty or its
    // current beat is leaving this cycle.
    logic out_free;
    logic accept;

    assign out_free = !valid_q || ready_i;

    // Stall counter: counts edges where a live beat is held back, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_q && !ready_i && !flush_i && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

`ifdef PIPE_STAGE_REG_SKID_EN

    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              ready_q,      ready_d;

    // ready_q is a registered copy of !skid_valid. When the skid is full,
    // ready_q is low, so the output register and the skid never both want
    // the same incoming beat.
    assign accept  = valid_i && ready_q;
    assign ready_o = ready_q;

    // Next-state logic for the output register and skid. Flush wins over
    // everything. A freed output register drains the skid before it takes
    // new input, which keeps beats in order.
    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;

        if (flush_i) begin
            valid_d      = 1'b0;
            ctrl_d       = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                valid_d      = 1'b1;
                ctrl_d       = skid_ctrl_q;
                data_d       = skid_data_q;
                skid_valid_d = 1'b0;
                skid_ctrl_d  = '0;
            end else if (accept) begin
                valid_d = 1'b1;
                ctrl_d  = ctrl_i;
                data_d  = data_i;
            end else begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = ctrl_i;
            skid_data_d  = data_i;
        end

        ready_d = !skid_valid_d;
    end

    // Skid state registers; reset leaves the skid empty and ready asserted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            ready_q      <= 1'b1;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
        end
    end

`else

    assign ready_o = out_free;
    assign accept  = valid_i && out_free;

    // Next-state logic for the output register. Flush wins. A stalled
    // output holds. A free output loads the incoming beat or becomes a
    // bubble.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;

        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (out_free) begin
            if (accept) begin
                valid_d = 1'b1;
                ctrl_d  = ctrl_i;
                data_d  = data_i;
            end else begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
        end
    end

`endif

    // Output and counter registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            data_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign valid_o     = valid_q;
    assign ctrl_o      = ctrl_q;
    assign data_o      = data_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, scoreboard-based bench for pipe_stage_reg. A second instance
// with CNT_W = 4 shares the same stimulus so that counter saturation can be
// observed.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic        flush_i;
    logic        ready_i;
    logic [3:0]  ctrl_i;
    logic [68:0] data_i;

    logic        ready_o, valid_o;
    logic [3:0]  ctrl_o;
    logic [68:0] data_o;
    logic [15:0] stall_cnt_o;

    logic        s_ready_o, s_valid_o;
    logic [3:0]  s_ctrl_o;
    logic [68:0] s_data_o;
    logic [3:0]  s_stall_cnt_o;

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(69), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
        .ctrl_i(ctrl_i), .data_i(data_i), .flush_i(flush_i), .valid_o(valid_o),
        .ready_i(ready_i), .ctrl_o(ctrl_o), .data_o(data_o), .stall_cnt_o(stall_cnt_o)
    );

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(69), .CNT_W(4)) dut_sat (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(s_ready_o),
        .ctrl_i(ctrl_i), .data_i(data_i), .flush_i(flush_i), .valid_o(s_valid_o),
        .ready_i(ready_i), .ctrl_o(s_ctrl_o), .data_o(s_data_o), .stall_cnt_o(s_stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    logic [72:0] sb[$];

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample the handshakes at the negative edge, update the scoreboard,
    // then return just after the next rising edge.
    task automatic tick();
        logic [72:0] head;
        @(negedge clk_i);
        if (rst_n_i) begin
            if (valid_o) begin
                if (ready_i) begin
                    n_cmp++;
                    assert (sb.size() != 0) else begin
                        n_fail++;
                        $error("FAIL sb_unexpected_beat: observed %0h expected none", {ctrl_o, data_o});
                    end
                    if (sb.size() != 0) begin
                        head = sb.pop_front();
                        chk("sb_beat", {23'd0, ctrl_o, data_o}, {23'd0, head});
                    end
                end
            end else begin
                chk("bubble_ctrl", {92'd0, ctrl_o}, 96'd0);
            end
            if (flush_i) begin
                sb.delete();
            end else if (valid_i && ready_o) begin
                sb.push_back({ctrl_i, data_i});
                n_acc++;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [68:0] rnd69();
        return 69'({$urandom, $urandom, $urandom});
    endfunction

    initial begin
        logic [68:0] a_d, b_d, c_d, g_d, last_d;
        int          acc0;
        int          exp_sat;

        // Hold reset with random inputs; outputs must stay cleared.
        rst_n_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'($urandom);
            flush_i = 1'($urandom);
            ready_i = 1'($urandom);
            ctrl_i  = 4'($urandom);
            data_i  = rnd69();
            #2;
            chk("rst_valid", {95'd0, valid_o}, 96'd0);
            chk("rst_ctrl", {92'd0, ctrl_o}, 96'd0);
            chk("rst_data", {27'd0, data_o}, 96'd0);
            chk("rst_cnt", {80'd0, stall_cnt_o}, 96'd0);
            chk("rst_ready", {95'd0, ready_o}, 96'd1);
            #8;
        end

        // Release reset; first beat must appear after one edge.
        @(posedge clk_i);
        #1;
        valid_i = 1'b1;
        ctrl_i  = 4'b1011;
        data_i  = 69'h1234;
        ready_i = 1'b1;
        flush_i = 1'b0;
        rst_n_i = 1'b1;
        #1;
        chk("first_ready", {95'd0, ready_o}, 96'd1);
        tick();
        chk("first_valid", {95'd0, valid_o}, 96'd1);
        chk("first_ctrl", {92'd0, ctrl_o}, 96'hb);
        chk("first_data", {27'd0, data_o}, 96'h1234);

        // Stream 100 back-to-back beats.
        last_d = '0;
        for (int i = 0; i < 100; i++) begin
            ctrl_i = 4'($urandom);
            data_i = rnd69();
            last_d = data_i;
            tick();
            chk("stream_valid", {95'd0, valid_o}, 96'd1);
        end
        chk("stream_accepted", 96'(n_acc), 96'd101);
        valid_i = 1'b0;
        tick();
        chk("drain_valid", {95'd0, valid_o}, 96'd0);
        chk("drain_ctrl", {92'd0, ctrl_o}, 96'd0);
        chk("drain_data_hold", {27'd0, data_o}, {27'd0, last_d});
        chk("drain_cnt", {80'd0, stall_cnt_o}, 96'd0);

        // Stall for 5 cycles with beat A held and beat B offered.
        a_d = rnd69();
        b_d = rnd69();
        valid_i = 1'b1;
        ctrl_i  = 4'h5;
        data_i  = a_d;
        tick();
        chk("stall_load_valid", {95'd0, valid_o}, 96'd1);
        ready_i = 1'b0;
        ctrl_i  = 4'h6;
        data_i  = b_d;
        acc0    = n_acc;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (n_acc != acc0) valid_i = 1'b0;
            chk("stall_valid", {95'd0, valid_o}, 96'd1);
            chk("stall_ctrl", {92'd0, ctrl_o}, 96'h5);
            chk("stall_data", {27'd0, data_o}, {27'd0, a_d});
            chk("stall_cnt", {80'd0, stall_cnt_o}, 96'(k));
            chk("stall_cnt_sat_inst", {92'd0, s_stall_cnt_o}, 96'(k));
            chk("stall_ready", {95'd0, ready_o}, 96'd0);
        end
        chk("stall_absorbed", 96'(n_acc - acc0), 96'(SKID));
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk("unstall_valid", {95'd0, valid_o}, 96'd1);
        chk("unstall_ctrl", {92'd0, ctrl_o}, 96'h6);
        chk("unstall_data", {27'd0, data_o}, {27'd0, b_d});
        chk("unstall_ready", {95'd0, ready_o}, 96'd1);
        tick();
        chk("unstall_drain", {95'd0, valid_o}, 96'd0);

        // Flush during a stall with the skid (if present) occupied.
        c_d = rnd69();
        valid_i = 1'b1;
        ctrl_i  = 4'h7;
        data_i  = c_d;
        tick();
        chk("flush_load_valid", {95'd0, valid_o}, 96'd1);
        ready_i = 1'b0;
        ctrl_i  = 4'h8;
        data_i  = rnd69();
        tick();
        chk("flush_pre_cnt", {80'd0, stall_cnt_o}, 96'd6);
        chk("flush_pre_ready", {95'd0, ready_o}, 96'd0);
        ctrl_i  = 4'h9;
        data_i  = rnd69();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("flush_valid", {95'd0, valid_o}, 96'd0);
        chk("flush_ctrl", {92'd0, ctrl_o}, 96'd0);
        chk("flush_data_hold", {27'd0, data_o}, {27'd0, c_d});
        chk("flush_ready", {95'd0, ready_o}, 96'd1);
        chk("flush_cnt", {80'd0, stall_cnt_o}, 96'd6);
        ready_i = 1'b1;
        tick();
        chk("flush_lost", {95'd0, valid_o}, 96'd0);

        // Flush with an empty output must drop the beat offered that cycle.
        valid_i = 1'b1;
        ctrl_i  = 4'hf;
        data_i  = rnd69();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("flush_in_valid", {95'd0, valid_o}, 96'd0);
        chk("flush_in_data", {27'd0, data_o}, {27'd0, c_d});
        chk("flush_sb_empty", 96'(sb.size()), 96'd0);

        // Saturation: 20 stall cycles.
        g_d = rnd69();
        valid_i = 1'b1;
        ctrl_i  = 4'ha;
        data_i  = g_d;
        tick();
        valid_i = 1'b0;
        ready_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_sat = (6 + k > 15) ? 15 : 6 + k;
            chk("sat_cnt4", {92'd0, s_stall_cnt_o}, 96'(exp_sat));
            chk("sat_cnt16", {80'd0, stall_cnt_o}, 96'(6 + k));
        end
        chk("sat_hold_valid", {95'd0, valid_o}, 96'd1);
        chk("sat_hold_data", {27'd0, data_o}, {27'd0, g_d});

        // Reset asserted mid-stall clears everything immediately.
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("midrst_valid", {95'd0, valid_o}, 96'd0);
        chk("midrst_ctrl", {92'd0, ctrl_o}, 96'd0);
        chk("midrst_data", {27'd0, data_o}, 96'd0);
        chk("midrst_cnt", {80'd0, stall_cnt_o}, 96'd0);
        chk("midrst_cnt4", {92'd0, s_stall_cnt_o}, 96'd0);
        chk("midrst_ready", {95'd0, ready_o}, 96'd1);
        sb.delete();
        @(negedge clk_i);
        #1;
        rst_n_i = 1'b1;
        ready_i = 1'b1;
        tick();
        chk("midrst_discard", {95'd0, valid_o}, 96'd0);
        chk("final_sb_empty", 96'(sb.size()), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Guard against a hang.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 4, meaning the width of the control bundle (writeBack, memtoReg, memRead, memWrite).
REQ-002 The block SHALL have parameter DATA_W, default 69, meaning the width of the data bundle (ALU result 32, store data 32, destination register 5).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the stall counter.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port valid_i, input, 1 bit: the upstream stage presents an instruction.
REQ-007 The block SHALL have port ready_o, output, 1 bit: the stage accepts this cycle.
REQ-008 The block SHALL have port ctrl_i, input, CTRL_W bits: upstream control bundle.
REQ-009 The block SHALL have port data_i, input, DATA_W bits: upstream data bundle.
REQ-010 The block SHALL have port flush_i, input, 1 bit: kill all held and incoming contents.
REQ-011 The block SHALL have port valid_o, output, 1 bit: the output holds a live instruction.
REQ-012 The block SHALL have port ready_i, input, 1 bit: downstream accepts (0 = stall).
REQ-013 The block SHALL have port ctrl_o, output, CTRL_W bits: registered control bundle.
REQ-014 The block SHALL have port data_o, output, DATA_W bits: registered data bundle.
REQ-015 The block SHALL have port stall_cnt_o, output, CNT_W bits: saturating count of stalled cycles.

Function
REQ-016 The block SHALL treat a beat as transferred when valid_i&&ready_o at the input, or valid_o&&ready_i at the output.
REQ-017 An accepted beat SHALL appear on valid_o/ctrl_o/data_o on the next rising edge (latency 1).
REQ-018 ctrl_o SHALL be all-zero whenever valid_o=0, so that a bubble never writes memory or the register file.
REQ-019 data_o SHALL hold its last loaded value while no new beat is loaded.
REQ-020 When valid_o=1 and ready_i=0, the outputs SHALL hold unchanged (no loss, no duplication).
REQ-021 When flush_i=1, the next edge SHALL clear valid_o, ctrl_o and any skid entry, and SHALL discard any beat accepted in the same cycle; flush takes priority over load and stall.
REQ-022 When flush_i=1, data_o SHALL remain unchanged.
REQ-023 stall_cnt_o SHALL increment by 1 on every edge where valid_o=1, ready_i=0 and flush_i=0.
REQ-024 stall_cnt_o SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-025 With valid_i=1 and ready_i=1 held continuously, the block SHALL sustain one beat per cycle.

Reset
REQ-026 While rst_n_i=0, the block SHALL immediately force valid_o=0, ctrl_o=0, data_o=0, stall_cnt_o=0 and skid entry empty, independent of clk_i.
REQ-027 On reset release, ready_o SHALL be 1 in the first cycle.
REQ-028 Reset asserted mid-stall SHALL discard all held beats.

Configuration
REQ-029 The block SHALL compile the skid buffer in or out with the macro PIPE_STAGE_REG_SKID_EN.
REQ-030 Without PIPE_STAGE_REG_SKID_EN, ready_o SHALL equal !valid_o || ready_i (combinational path from ready_i).
REQ-031 With PIPE_STAGE_REG_SKID_EN, ready_o SHALL be driven directly from a flop as !skid_valid, and a beat accepted while the output is stalled SHALL be stored in a one-entry skid.
REQ-032 With PIPE_STAGE_REG_SKID_EN, the skid entry SHALL move to the output on the first edge with ready_i=1, and ready_o SHALL return to 1 the cycle after.
REQ-033 With PIPE_STAGE_REG_SKID_EN, ordering SHALL be preserved: the output beat first, then the skid beat, then new input.

Verification
REQ-034 Reset test: hold rst_n_i=0 with random inputs -> all outputs 0 and ready_o=1; release -> first beat ctrl_i=4'b1011, data_i=69'h1234 appears on the next edge.
REQ-035 Stream test: 100 back-to-back beats with ready_i=1 -> 100 outputs, in order, one per cycle, with no gaps.
REQ-036 Stall test: ready_i=0 for 5 cycles with valid_o=1 -> outputs frozen and stall_cnt_o increases by 5; with SKID_EN, exactly one extra beat is absorbed and ready_o=0 after it.
REQ-037 Flush test: flush_i=1 during a stall with a skid entry full and valid_i=1 -> next cycle valid_o=0, ctrl_o=0, data_o unchanged, skid empty, and the incoming beat is lost.
REQ-038 Saturation test: CNT_W=4 with 20 stall cycles -> stall_cnt_o=4'hF, no wrap.
